ulpi_reg_read: RTL and testbench

//  Link-side ULPI register-read engine; the read counterpart of the ULPI register-write sequencer.
//  - Issues a TXCMD of 11aaaaaa, tracks NXT/DIR turnaround and captures the PHY-returned register byte.
//  - Retries when the PHY aborts, and times out on a stalled PHY.
//  - Also reports RXCMD bytes seen while the bus is idle.
//  - Sits between the USB control logic and the top-level ULPI tri-state pad.

---
 rtl/ulpi_reg_read_if.sv | 46 ++++
 rtl/ulpi_reg_read.sv | 247 ++++++++++++++++++++++++
 tb/tb_ulpi_reg_read.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ulpi_reg_read_if.sv
// ulpi_reg_read_if
//   This bundle groups the signals between the register-read engine and the
//   blocks around it. It has two sides:
//     - Requester side: USB control logic.
//     - PHY side: ULPI pad wiring.
//   slave  : the view of the engine itself (ulpi_reg_read).
//   master : the view of whatever drives the engine, i.e. the requester plus
//            the PHY/pad environment.
//   Signals:
//     rd_req/rd_addr                     read request and 6-bit register address
//     rd_busy/rd_done/rd_err/rd_data     read status and returned byte
//     rxcmd_valid/rxcmd                  RXCMD bytes observed while the bus is idle
//     ulpi_dir/ulpi_nxt/ulpi_data_in     PHY-driven ULPI lines
//     ulpi_stp/ulpi_data_out/ulpi_data_oe  link-driven ULPI lines
interface ulpi_reg_read_if;
  logic       rd_req;
  logic [5:0] rd_addr;
  logic       rd_busy;
  logic       rd_done;
  logic       rd_err;
  logic [7:0] rd_data;
  logic       rxcmd_valid;
  logic [7:0] rxcmd;
  logic       ulpi_dir;
  logic       ulpi_nxt;
  logic       ulpi_stp;
  logic [7:0] ulpi_data_in;
  logic [7:0] ulpi_data_out;
  logic       ulpi_data_oe;

  modport slave (
    input  rd_req, rd_addr,
    input  ulpi_dir, ulpi_nxt, ulpi_data_in,
    output rd_busy, rd_done, rd_err, rd_data,
    output rxcmd_valid, rxcmd,
    output ulpi_stp, ulpi_data_out, ulpi_data_oe
  );

  modport master (
    output rd_req, rd_addr,
    output ulpi_dir, ulpi_nxt, ulpi_data_in,
    input  rd_busy, rd_done, rd_err, rd_data,
    input  rxcmd_valid, rxcmd,
    input  ulpi_stp, ulpi_data_out, ulpi_data_oe
  );
endinterface

// File: rtl/ulpi_reg_read.sv
// ulpi_reg_read
//   Link-side ULPI register-read engine.
//   Operation:
//     - Issues a TXCMD byte of 11aaaaaa.
//     - Follows the NXT/DIR turnaround sequence.
//     - Captures the register byte returned by the PHY.
//   Error handling:
//     - Re-issues the command when the PHY aborts by raising DIR during TXCMD.
//     - Gives up after MAX_RETRY re-issues.
//     - Reports a timeout when a wait state stalls for TIMEOUT_CYCLES.
//   While the bus is idle, RXCMD bytes sent by the PHY are captured and reported.
//   Ports:
//     CLKOUT  60 MHz ULPI clock from the PHY (only clock)
//     reset   asynchronous, active-low reset
//     bus     ulpi_reg_read_if.slave; carries the following signals:
//       - Request/status: rd_req, rd_addr, rd_busy, rd_done, rd_err, rd_data.
//       - RXCMD report:   rxcmd_valid, rxcmd.
//       - ULPI lines:     dir, nxt, stp, data_in, data_out, data_oe.
//   Parameters:
//     TIMEOUT_CYCLES  cycles allowed in each of TXCMD/TURN1/TURN2 (1..65535)
//     MAX_RETRY       re-issues allowed after PHY abort (0..15)
module ulpi_reg_read #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_RETRY      = 3
) (
  input logic            CLKOUT,
  input logic            reset,
  ulpi_reg_read_if.slave bus
);

  localparam logic [2:0] ST_IDLE       = 3'd0;
  localparam logic [2:0] ST_TXCMD      = 3'd1;
  localparam logic [2:0] ST_TURN1      = 3'd2;
  localparam logic [2:0] ST_RDATA      = 3'd3;
  localparam logic [2:0] ST_TURN2      = 3'd4;
  localparam logic [2:0] ST_ABORT_WAIT = 3'd5;

  // The timer starts at 0 on state entry. The last permitted wait cycle is the
  // one where the timer reads TIMEOUT_CYCLES-1, so with TIMEOUT_CYCLES=N an
  // unanswered TXCMD completes N edges after it was entered.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  // The retry count can reach MAX_RETRY+1 (up to 16), so it is one bit wider
  // than MAX_RETRY itself.
  localparam logic [4:0] RETRY_LIMIT = 5'(MAX_RETRY);

  logic [2:0]  state_reg, state_next;
  logic [5:0]  addr_reg, addr_next;
  logic [4:0]  retry_reg, retry_next;
  logic [15:0] timer_reg, timer_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;
  logic [7:0]  data_reg, data_next;
  logic        rxv_reg, rxv_next;
  logic [7:0]  rxcmd_reg, rxcmd_next;
  logic [7:0]  dout_reg, dout_next;
  logic        dir_q_reg;
  logic        stp_reg;

  logic        timed_out;
  logic        wait_state;
  logic        rx_window;

  function automatic logic [7:0] txcmd_byte(input logic [5:0] addr);
    return {2'b11, addr};
  endfunction

  assign timed_out  = (timer_reg == TIMEOUT_LAST);
  assign wait_state = (state_reg == ST_TXCMD) || (state_reg == ST_TURN1) ||
                      (state_reg == ST_TURN2);

  // RXCMD bytes are only meaningful while no register read owns the bus.
  assign rx_window  = (state_reg == ST_IDLE) || (state_reg == ST_ABORT_WAIT);

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    retry_next = retry_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    err_next   = err_reg;
    data_next  = data_reg;
    rxv_next   = 1'b0;
    rxcmd_next = rxcmd_reg;
    dout_next  = dout_reg;

    case (state_reg)
      ST_IDLE: begin
        // A request made while the PHY owns the bus is left pending until DIR
        // drops.
        if (bus.rd_req && !bus.ulpi_dir) begin
          addr_next  = bus.rd_addr;
          retry_next = 5'd0;
          dout_next  = txcmd_byte(bus.rd_addr);
          busy_next  = 1'b1;
          state_next = ST_TXCMD;
        end
      end

      ST_TXCMD: begin
        // A PHY abort outranks NXT. If both arrive in the same cycle, the PHY
        // has already taken the bus.
        if (bus.ulpi_dir) begin
          dout_next  = 8'h00;
          retry_next = retry_reg + 5'd1;
          state_next = ST_ABORT_WAIT;
        end else if (bus.ulpi_nxt) begin
          dout_next  = 8'h00;
          state_next = ST_TURN1;
        end else if (timed_out) begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          busy_next  = 1'b0;
          dout_next  = 8'h00;
          state_next = ST_IDLE;
        end
      end

      ST_TURN1: begin
        if (bus.ulpi_dir) begin
          state_next = ST_RDATA;
        end else if (timed_out) begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end

      ST_RDATA: begin
        // The register byte is valid on the first cycle after the turnaround.
        // If DIR is already low at this point, the PHY did not deliver it.
        if (bus.ulpi_dir) begin
          data_next  = bus.ulpi_data_in;
          state_next = ST_TURN2;
        end else begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end

      ST_TURN2: begin
        if (!bus.ulpi_dir) begin
          done_next  = 1'b1;
          err_next   = 1'b0;
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end else if (timed_out) begin
          done_next  = 1'b1;
          err_next   = 1'b1;
          busy_next  = 1'b0;
          state_next = ST_IDLE;
        end
      end

      ST_ABORT_WAIT: begin
        // No timeout applies here. The PHY holds DIR for as long as its own
        // traffic requires.
        if (!bus.ulpi_dir) begin
          if (retry_reg <= RETRY_LIMIT) begin
            dout_next  = txcmd_byte(addr_reg);
            state_next = ST_TXCMD;
          end else begin
            done_next  = 1'b1;
            err_next   = 1'b1;
            busy_next  = 1'b0;
            state_next = ST_IDLE;
          end
        end
      end

      default: begin
        dout_next  = 8'h00;
        busy_next  = 1'b0;
        state_next = ST_IDLE;
      end
    endcase

    // Capture conditions:
    //   - DIR must have been high in the previous cycle as well. This skips
    //     the turnaround cycle.
    //   - NXT must be low. NXT high marks USB receive data, not an RXCMD.
    if (rx_window && bus.ulpi_dir && dir_q_reg && !bus.ulpi_nxt) begin
      rxcmd_next = bus.ulpi_data_in;
      rxv_next   = 1'b1;
    end
  end

  // Re-entering TXCMD from ABORT_WAIT counts as a fresh entry, so the timer
  // restarts.
  always_comb begin
    timer_next = 16'd0;
    if (wait_state && (state_next == state_reg)) begin
      timer_next = timer_reg + 16'd1;
    end
  end

  always_ff @(posedge CLKOUT or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      addr_reg  <= 6'd0;
      retry_reg <= 5'd0;
      timer_reg <= 16'd0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
      data_reg  <= 8'h00;
      rxv_reg   <= 1'b0;
      rxcmd_reg <= 8'h00;
      dout_reg  <= 8'h00;
      dir_q_reg <= 1'b0;
      stp_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      retry_reg <= retry_next;
      timer_reg <= timer_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
      data_reg  <= data_next;
      rxv_reg   <= rxv_next;
      rxcmd_reg <= rxcmd_next;
      dout_reg  <= dout_next;
      dir_q_reg <= bus.ulpi_dir;
      // Register reads never end a transfer, so STP stays low.
      stp_reg   <= 1'b0;
    end
  end

  assign bus.rd_busy       = busy_reg;
  assign bus.rd_done       = done_reg;
  assign bus.rd_err        = err_reg;
  assign bus.rd_data       = data_reg;
  assign bus.rxcmd_valid   = rxv_reg;
  assign bus.rxcmd         = rxcmd_reg;
  assign bus.ulpi_stp      = stp_reg;
  assign bus.ulpi_data_out = dout_reg;

  // The link drives the pad whenever the PHY does not. This output is left
  // combinational so the pad releases in the same cycle that DIR rises.
  assign bus.ulpi_data_oe  = ~bus.ulpi_dir;

endmodule

// File: tb/tb_ulpi_reg_read.sv
// tb_ulpi_reg_read
//   Drives a scripted ULPI PHY and a requester, cycle by cycle.
//   Each test task checks timing-sensitive outputs inline.
//   Scoreboard:
//     - Expected completions and RXCMD bytes are queued when stimulus is driven.
//     - A negedge monitor pops and compares them when the DUT reports them.
module tb_ulpi_reg_read;
  logic CLKOUT = 1'b0;
  logic reset  = 1'b0;

  always #5 CLKOUT = ~CLKOUT;

  ulpi_reg_read_if bus ();

  ulpi_reg_read #(
    .TIMEOUT_CYCLES(16),
    .MAX_RETRY     (2)
  ) dut (
    .CLKOUT(CLKOUT),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] rx_q[$];
  exp_t       exp_head;
  logic [7:0] rx_head;
  logic [7:0] last_data;
  int tests_run    = 0;
  int tests_failed = 0;

  // Scoreboard monitor: every completion and every RXCMD pulse must match a
  // queued expectation.
  always @(negedge CLKOUT) begin
    if (reset) begin
      if (bus.rd_done) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected_done: got rd_done=1 err=%0b data=%02h, required no completion",
                   bus.rd_err, bus.rd_data);
        end else begin
          exp_head = exp_q.pop_front();
          if ({bus.rd_err, bus.rd_data} !== {exp_head.err, exp_head.data}) begin
            tests_failed++;
            $display("FAIL sb_done: got err=%0b data=%02h, required err=%0b data=%02h",
                     bus.rd_err, bus.rd_data, exp_head.err, exp_head.data);
          end else begin
            $display("[TB] done err=%0b data=%02h", bus.rd_err, bus.rd_data);
          end
        end
      end
      if (bus.rxcmd_valid) begin
        tests_run++;
        if (rx_q.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected_rxcmd: got rxcmd=%02h, required no pulse", bus.rxcmd);
        end else begin
          rx_head = rx_q.pop_front();
          if (bus.rxcmd !== rx_head) begin
            tests_failed++;
            $display("FAIL sb_rxcmd: got %02h, required %02h", bus.rxcmd, rx_head);
          end else begin
            $display("[TB] rxcmd %02h", bus.rxcmd);
          end
        end
      end
    end
  end

  task automatic cyc();
    @(posedge CLKOUT);
    #1;
  endtask

  // Called right after the edge that entered TURN1.
  // Sequence: turnaround cycle, data cycle, then DIR drops.
  task automatic phy_return(input logic [7:0] d);
    bus.ulpi_nxt     = 1'b0;
    bus.ulpi_dir     = 1'b1;
    cyc();
    bus.ulpi_data_in = d;
    cyc();
    bus.ulpi_dir     = 1'b0;
    bus.ulpi_data_in = 8'h00;
    cyc();
  endtask

  task automatic test_reset();
    bus.rd_req = 1'b0;
    bus.rd_addr = 6'd0;
    bus.ulpi_dir = 1'b0;
    bus.ulpi_nxt = 1'b0;
    bus.ulpi_data_in = 8'h00;
    reset = 1'b0;
    repeat (3) cyc();
    tests_run++;
    if ({bus.rd_busy, bus.rd_done, bus.rd_err, bus.rxcmd_valid, bus.ulpi_stp} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: got busy/done/err/rxv/stp=%05b, required 00000",
               {bus.rd_busy, bus.rd_done, bus.rd_err, bus.rxcmd_valid, bus.ulpi_stp});
    end
    tests_run++;
    if ({bus.rd_data, bus.rxcmd, bus.ulpi_data_out} !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset_bytes: got data=%02h rxcmd=%02h dout=%02h, required 00 00 00",
               bus.rd_data, bus.rxcmd, bus.ulpi_data_out);
    end
    tests_run++;
    if (bus.ulpi_data_oe !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_oe: got %0b, required 1", bus.ulpi_data_oe);
    end
    reset = 1'b1;
    cyc();
    last_data = 8'h00;
    $display("[TB] reset checked");
  endtask

  task automatic test_basic_read();
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'h00;
    exp_q.push_back('{err: 1'b0, data: 8'h24});
    cyc();
    bus.rd_req = 1'b0;
    tests_run++;
    if (bus.ulpi_data_out !== 8'hC0 || bus.rd_busy !== 1'b1 || bus.ulpi_data_oe !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_txcmd: got dout=%02h busy=%0b oe=%0b, required C0 1 1",
               bus.ulpi_data_out, bus.rd_busy, bus.ulpi_data_oe);
    end
    bus.ulpi_nxt = 1'b1;
    cyc();
    tests_run++;
    if (bus.ulpi_data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL basic_txcmd_len: got dout=%02h after 1 cycle, required 00", bus.ulpi_data_out);
    end
    phy_return(8'h24);
    tests_run++;
    if (bus.rd_done !== 1'b1 || bus.rd_err !== 1'b0 || bus.rd_data !== 8'h24 || bus.rd_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_latency: 4th clock got done=%0b err=%0b data=%02h busy=%0b, required 1 0 24 0",
               bus.rd_done, bus.rd_err, bus.rd_data, bus.rd_busy);
    end
    last_data = 8'h24;
    $display("[TB] basic read 00 -> 24");
  endtask

  task automatic test_delayed_nxt();
    bit bad = 1'b0;
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'h02;
    exp_q.push_back('{err: 1'b0, data: 8'h04});
    cyc();
    bus.rd_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.ulpi_data_out !== 8'hC2 || bus.ulpi_data_oe !== 1'b1) bad = 1'b1;
      if (i == 3) bus.ulpi_nxt = 1'b1;
      cyc();
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL delayed_txcmd: got unstable dout/oe within 4 cycles, required C2 with oe=1");
    end
    tests_run++;
    if (bus.ulpi_data_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL delayed_release: got dout=%02h, required 00", bus.ulpi_data_out);
    end
    phy_return(8'h04);
    tests_run++;
    if (bus.rd_done !== 1'b1 || bus.rd_data !== 8'h04) begin
      tests_failed++;
      $display("FAIL delayed_done: got done=%0b data=%02h, required 1 04", bus.rd_done, bus.rd_data);
    end
    last_data = 8'h04;
    $display("[TB] delayed nxt read 02 -> 04");
  endtask

  task automatic test_abort_retry();
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'h00;
    exp_q.push_back('{err: 1'b0, data: 8'h24});
    cyc();
    bus.rd_req = 1'b0;
    bus.ulpi_dir = 1'b1;
    cyc();
    tests_run++;
    if (bus.ulpi_data_out !== 8'h00 || bus.ulpi_data_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_release: got dout=%02h oe=%0b, required 00 0", bus.ulpi_data_out, bus.ulpi_data_oe);
    end
    bus.ulpi_data_in = 8'h4A;
    rx_q.push_back(8'h4A);
    cyc();
    tests_run++;
    if (bus.rxcmd_valid !== 1'b1 || bus.rxcmd !== 8'h4A) begin
      tests_failed++;
      $display("FAIL abort_rxcmd: got valid=%0b rxcmd=%02h, required 1 4A", bus.rxcmd_valid, bus.rxcmd);
    end
    bus.ulpi_dir = 1'b0;
    bus.ulpi_data_in = 8'h00;
    cyc();
    tests_run++;
    if (bus.ulpi_data_out !== 8'hC0 || bus.rd_busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL abort_reissue: got dout=%02h busy=%0b, required C0 1", bus.ulpi_data_out, bus.rd_busy);
    end
    bus.ulpi_nxt = 1'b1;
    cyc();
    phy_return(8'h24);
    tests_run++;
    if (bus.rd_done !== 1'b1 || bus.rd_data !== 8'h24) begin
      tests_failed++;
      $display("FAIL abort_done: got done=%0b data=%02h, required 1 24", bus.rd_done, bus.rd_data);
    end
    last_data = 8'h24;
    $display("[TB] abort+retry read 00 -> 24");
  endtask

  task automatic test_retry_exhaust();
    bit bad = 1'b0;
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'h05;
    exp_q.push_back('{err: 1'b1, data: last_data});
    cyc();
    bus.rd_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.ulpi_dir = 1'b1;
      cyc();
      bus.ulpi_dir = 1'b0;
      cyc();
      if (i < 2 && (bus.rd_busy !== 1'b1 || bus.rd_done !== 1'b0 || bus.ulpi_data_out !== 8'hC5)) bad = 1'b1;
    end
    tests_run++;
    if (bad) begin
      tests_failed++;
      $display("FAIL retry_reissue: got early completion or wrong reissue, required C5 reissued twice");
    end
    tests_run++;
    if (bus.rd_done !== 1'b1 || bus.rd_err !== 1'b1 || bus.rd_busy !== 1'b0 || bus.rd_data !== last_data) begin
      tests_failed++;
      $display("FAIL retry_exhaust: got done=%0b err=%0b busy=%0b data=%02h, required 1 1 0 %02h",
               bus.rd_done, bus.rd_err, bus.rd_busy, bus.rd_data, last_data);
    end
    $display("[TB] retries exhausted on 05");
  endtask

  task automatic test_timeout();
    bit early = 1'b0;
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'h03;
    exp_q.push_back('{err: 1'b1, data: last_data});
    cyc();
    bus.rd_req = 1'b0;
    for (int k = 1; k < 16; k++) begin
      cyc();
      if (bus.rd_done !== 1'b0 || bus.ulpi_data_out !== 8'hC3) early = 1'b1;
    end
    tests_run++;
    if (early) begin
      tests_failed++;
      $display("FAIL timeout_early: got completion or dout change before 16 cycles, required C3 held");
    end
    cyc();
    tests_run++;
    if (bus.rd_done !== 1'b1 || bus.rd_err !== 1'b1 || bus.ulpi_data_out !== 8'h00 || bus.rd_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_done: got done=%0b err=%0b dout=%02h busy=%0b, required 1 1 00 0",
               bus.rd_done, bus.rd_err, bus.ulpi_data_out, bus.rd_busy);
    end
    $display("[TB] timeout on 03");
  endtask

  task automatic test_rxcmd_idle();
    bus.ulpi_dir = 1'b1;
    bus.ulpi_data_in = 8'h11;
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'h07;
    cyc();
    tests_run++;
    if (bus.rxcmd_valid !== 1'b0 || bus.rd_busy !== 1'b0 || bus.ulpi_data_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_turnaround: got valid=%0b busy=%0b oe=%0b, required 0 0 0",
               bus.rxcmd_valid, bus.rd_busy, bus.ulpi_data_oe);
    end
    bus.ulpi_data_in = 8'h5A;
    rx_q.push_back(8'h5A);
    cyc();
    tests_run++;
    if (bus.rxcmd_valid !== 1'b1 || bus.rxcmd !== 8'h5A) begin
      tests_failed++;
      $display("FAIL rx_capture: got valid=%0b rxcmd=%02h, required 1 5A", bus.rxcmd_valid, bus.rxcmd);
    end
    bus.ulpi_nxt = 1'b1;
    bus.ulpi_data_in = 8'h99;
    cyc();
    tests_run++;
    if (bus.rxcmd_valid !== 1'b0 || bus.rxcmd !== 8'h5A || bus.rd_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL rx_ignore_data: got valid=%0b rxcmd=%02h busy=%0b, required 0 5A 0",
               bus.rxcmd_valid, bus.rxcmd, bus.rd_busy);
    end
    bus.ulpi_dir = 1'b0;
    bus.ulpi_nxt = 1'b0;
    bus.ulpi_data_in = 8'h00;
    exp_q.push_back('{err: 1'b0, data: 8'h3C});
    cyc();
    tests_run++;
    if (bus.rd_busy !== 1'b1 || bus.ulpi_data_out !== 8'hC7) begin
      tests_failed++;
      $display("FAIL rx_pending_req: got busy=%0b dout=%02h, required 1 C7", bus.rd_busy, bus.ulpi_data_out);
    end
    bus.rd_req = 1'b0;
    bus.ulpi_nxt = 1'b1;
    cyc();
    phy_return(8'h3C);
    last_data = 8'h3C;
    $display("[TB] idle rxcmd 5A, pending read 07 -> 3C");
  endtask

  task automatic test_back_to_back();
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'h01;
    exp_q.push_back('{err: 1'b0, data: 8'h04});
    cyc();
    bus.rd_req = 1'b0;
    bus.ulpi_nxt = 1'b1;
    cyc();
    phy_return(8'h04);
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'h00;
    exp_q.push_back('{err: 1'b0, data: 8'h24});
    cyc();
    tests_run++;
    if (bus.rd_busy !== 1'b1 || bus.ulpi_data_out !== 8'hC0) begin
      tests_failed++;
      $display("FAIL b2b_accept: got busy=%0b dout=%02h, required 1 C0", bus.rd_busy, bus.ulpi_data_out);
    end
    bus.rd_req = 1'b0;
    bus.ulpi_nxt = 1'b1;
    cyc();
    phy_return(8'h24);
    last_data = 8'h24;
    $display("[TB] back-to-back 01 -> 04, 00 -> 24");
  endtask

  task automatic test_reset_mid_read();
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'h00;
    cyc();
    bus.rd_req = 1'b0;
    bus.ulpi_nxt = 1'b1;
    cyc();
    bus.ulpi_nxt = 1'b0;
    bus.ulpi_dir = 1'b1;
    cyc();
    bus.ulpi_data_in = 8'h24;
    reset = 1'b0;
    #1;
    tests_run++;
    if ({bus.rd_busy, bus.rd_done, bus.rd_err, bus.rxcmd_valid, bus.ulpi_stp} !== 5'b0 ||
        {bus.rd_data, bus.rxcmd, bus.ulpi_data_out} !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset_mid: got busy=%0b done=%0b err=%0b data=%02h rxcmd=%02h dout=%02h, required all 0",
               bus.rd_busy, bus.rd_done, bus.rd_err, bus.rd_data, bus.rxcmd, bus.ulpi_data_out);
    end
    bus.ulpi_dir = 1'b0;
    bus.ulpi_data_in = 8'h00;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    bus.rd_req = 1'b1;
    bus.rd_addr = 6'h01;
    exp_q.push_back('{err: 1'b0, data: 8'h04});
    cyc();
    tests_run++;
    if (bus.ulpi_data_out !== 8'hC1 || bus.rd_done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_restart: got dout=%02h done=%0b, required C1 0", bus.ulpi_data_out, bus.rd_done);
    end
    bus.rd_req = 1'b0;
    bus.ulpi_nxt = 1'b1;
    cyc();
    phy_return(8'h04);
    tests_run++;
    if (bus.rd_done !== 1'b1 || bus.rd_data !== 8'h04 || bus.rd_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_next_read: got done=%0b err=%0b data=%02h, required 1 0 04",
               bus.rd_done, bus.rd_err, bus.rd_data);
    end
    $display("[TB] reset mid-read, then 01 -> 04");
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_delayed_nxt();
    test_abort_retry();
    test_retry_exhaust();
    test_timeout();
    test_rxcmd_idle();
    test_back_to_back();
    test_reset_mid_read();
    repeat (3) cyc();
    tests_run++;
    if (exp_q.size() != 0 || rx_q.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: got %0d completions and %0d rxcmds outstanding, required 0 0",
               exp_q.size(), rx_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
